// File: rtl/series_trig_engine.sv
// -----------------------------------------------------------------------------
// series_trig_engine
//   Fixed-point series evaluator: result = v * f(x), f = cos(x) or sin(x),
//   from a truncated Taylor series of TERMS terms. One shared multiplier
//   and one adder, sequenced by a small FSM with a start/busy/done handshake.
//
// Parameters
//   WIDTH  data width, signed two's complement
//   FRAC   fractional bits (format Q(WIDTH-FRAC).FRAC)
//   TERMS  series terms, 1..8
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   request, sampled only in IDLE
//   mode    0 = cos, 1 = sin, sampled with start
//   x       angle in radians, sampled with start
//   v       scale factor, sampled with start
//   busy    high while a computation is in progress
//   done    one-cycle pulse when result is updated
//   result  v*f(x), held until the next completion
// -----------------------------------------------------------------------------
module series_trig_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 11,
    parameter int TERMS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] v,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] result
);

    typedef enum logic [2:0] {
        IDLE, LOAD, ACC, REMULT, SCALE, DONE
    } state_e;

    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);

    // Ratio between successive series terms, without the x^2 factor:
    // r_k = -round(2^FRAC / d_k). Only ever called with constant arguments.
    function automatic logic signed [WIDTH-1:0] ratio(input int d);
        return WIDTH'(-(((1 << FRAC) + d / 2) / d));
    endfunction

    logic signed [WIDTH-1:0] cos_rom [8];
    logic signed [WIDTH-1:0] sin_rom [8];

    for (genvar k = 0; k < 8; k++) begin : g_rom
        assign cos_rom[k] = ratio((2 * k + 1) * (2 * k + 2));
        assign sin_rom[k] = ratio((2 * k + 2) * (2 * k + 3));
    end

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] xr_q, xr_d;
    logic signed [WIDTH-1:0] vr_q, vr_d;
    logic signed [WIDTH-1:0] x2_q, x2_d;
    logic signed [WIDTH-1:0] term_q, term_d;
    logic signed [WIDTH-1:0] expr_q, expr_d;
    logic signed [WIDTH-1:0] result_q, result_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    mode_q, mode_d;

    logic signed [WIDTH-1:0]   mul_a, mul_b, mul_y, rom_val;
    logic signed [2*WIDTH-1:0] prod;

    // Shared multiplier: operands chosen by state. The product is shifted
    // arithmetically (floor) and wrapped to WIDTH bits.
    always_comb begin
        rom_val = mode_q ? sin_rom[cnt_q[2:0]] : cos_rom[cnt_q[2:0]];
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            LOAD:    begin mul_a = xr_q;   mul_b = xr_q;    end
            ACC:     begin mul_a = term_q; mul_b = rom_val; end
            REMULT:  begin mul_a = term_q; mul_b = x2_q;    end
            SCALE:   begin mul_a = vr_q;   mul_b = expr_q;  end
            default: ;
        endcase
        prod  = mul_a * mul_b;
        mul_y = WIDTH'(prod >>> FRAC);
    end

    always_comb begin
        state_d  = state_q;
        xr_d     = xr_q;
        vr_d     = vr_q;
        x2_d     = x2_q;
        term_d   = term_q;
        expr_d   = expr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xr_d    = x;
                    vr_d    = v;
                    mode_d  = mode;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                x2_d    = mul_y;
                expr_d  = '0;
                cnt_d   = '0;
                term_d  = mode_q ? xr_q : ONE;
                state_d = ACC;
            end
            ACC: begin
                expr_d  = expr_q + term_q;
                term_d  = mul_y;
                cnt_d   = cnt_q + 4'd1;
                // The last term's ratio product is computed but never used.
                state_d = (cnt_d == 4'(TERMS)) ? SCALE : REMULT;
            end
            REMULT: begin
                term_d  = mul_y;
                state_d = ACC;
            end
            SCALE: begin
                result_d = mul_y;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            xr_q     <= '0;
            vr_q     <= '0;
            x2_q     <= '0;
            term_q   <= '0;
            expr_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // values from before this edge, independent of statement order.
            state_q  <= state_d;
            xr_q     <= xr_d;
            vr_q     <= vr_d;
            x2_q     <= x2_d;
            term_q   <= term_d;
            expr_q   <= expr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
        end
    end

    assign busy   = (state_q == LOAD) || (state_q == ACC) ||
                    (state_q == REMULT) || (state_q == SCALE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_series_trig_engine.sv
// -----------------------------------------------------------------------------
// tb_series_trig_engine
//   Self-checking bench for series_trig_engine. Expected results for the
//   default instance come from an independent fixed-point model, queued at
//   acceptance and compared when done pulses. Two extra instances cover
//   TERMS=1 and WIDTH=24/FRAC=16.
// -----------------------------------------------------------------------------
module tb_series_trig_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic               start = 1'b0;
    logic               mode_i = 1'b0;
    logic signed [15:0] x_i = '0, v_i = '0;
    logic               busy, done;
    logic signed [15:0] result;

    // TERMS = 1 instance (shares mode/x/v with the default instance)
    logic               start_t1 = 1'b0;
    logic               busy_t1, done_t1;
    logic signed [15:0] result_t1;

    // WIDTH = 24, FRAC = 16 instance
    logic               start_w = 1'b0;
    logic signed [23:0] x_w = '0, v_w = '0;
    logic               busy_w, done_w;
    logic signed [23:0] result_w;

    series_trig_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode_i),
        .x(x_i), .v(v_i), .busy(busy), .done(done), .result(result)
    );

    series_trig_engine #(.WIDTH(16), .FRAC(11), .TERMS(1)) dut_t1 (
        .clk(clk), .rst_n(rst_n), .start(start_t1), .mode(mode_i),
        .x(x_i), .v(v_i), .busy(busy_t1), .done(done_t1), .result(result_t1)
    );

    series_trig_engine #(.WIDTH(24), .FRAC(16), .TERMS(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .mode(1'b0),
        .x(x_w), .v(v_w), .busy(busy_w), .done(done_w), .result(result_w)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    logic signed [15:0] sb_q[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model, Q4.11, 8 terms
    localparam int COS_R [8] = '{-1024, -171, -68, -37, -23, -16, -11, -9};
    localparam int SIN_R [8] = '{-341, -102, -49, -28, -19, -13, -10, -8};

    function automatic logic signed [15:0] fmul(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
        logic signed [31:0] p;
        p = a * b;
        return p[26:11];
    endfunction

    function automatic logic signed [15:0] model(input logic md,
                                                 input logic signed [15:0] xa,
                                                 input logic signed [15:0] va);
        logic signed [15:0] t, x2, acc;
        x2  = fmul(xa, xa);
        t   = md ? xa : 16'sd2048;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc = acc + t;
            t   = fmul(t, 16'(md ? SIN_R[k] : COS_R[k]));
            if (k < 7) t = fmul(t, x2);
        end
        return fmul(va, acc);
    endfunction

    // Scoreboard: push on acceptance, pop on done. Reset drops pending work.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (done) begin
                n_done++;
                if (sb_q.size() == 0) check("unexpected_done", 1, 0);
                else check("result", result, sb_q.pop_front());
            end
            if (start && !busy && !done) sb_q.push_back(model(mode_i, x_i, v_i));
        end
    end

    // One operation on the default instance; reports latency in edges after
    // acceptance, busy cycles observed, and the result at done.
    task automatic do_op(input logic md, input logic signed [15:0] xa,
                         input logic signed [15:0] va, output int lat,
                         output int bcnt, output logic signed [15:0] res);
        @(posedge clk); #1;
        start = 1'b1; mode_i = md; x_i = xa; v_i = va;
        @(posedge clk); #1;
        start = 1'b0; mode_i = ~md; x_i = 16'($urandom); v_i = 16'($urandom);
        lat  = -1;
        bcnt = busy ? 1 : 0;
        res  = '0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    initial begin
        int lat, bcnt, nd, dcnt;
        int t [3];
        logic signed [15:0] res;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_result", result, 0);
        end

        // cos(0), v = 1.0
        do_op(1'b0, 16'sd0, 16'sd2048, lat, bcnt, res);
        check("cos0_latency", lat, 17);
        check("cos0_busy_cycles", bcnt, 17);
        check("cos0_value", res, 2048);

        // sin(0), then cos(1.0)
        do_op(1'b1, 16'sd0, 16'sd2048, lat, bcnt, res);
        check("sin0_value", res, 0);
        do_op(1'b0, 16'sd2048, 16'sd2048, lat, bcnt, res);
        check("cos1_tolerance", (res >= 1103 && res <= 1111), 1);
        check("cos1_latency", lat, 17);

        // sin(1.0) scaled by 2.0
        do_op(1'b1, 16'sd2048, 16'sd4096, lat, bcnt, res);
        check("sin1x2_tolerance", (res >= 3439 && res <= 3455), 1);

        // Random angles within +-pi/2 and scales within +-1.0
        for (int i = 0; i < 6; i++) begin
            do_op(1'($urandom), 16'($urandom_range(6432) - 3216),
                  16'($urandom_range(4096) - 2048), lat, bcnt, res);
            check("rand_latency", lat, 17);
        end

        // start held high: one operation per 19 cycles
        @(posedge clk); #1;
        mode_i = 1'b0; x_i = '0; v_i = 16'sd2048; start = 1'b1;
        nd = 0;
        t = '{0, 0, 0};
        for (int c = 0; c < 200 && nd < 3; c++) begin
            @(posedge clk); #1;
            if (done) begin
                t[nd] = c;
                nd++;
            end
        end
        start = 1'b0;
        check("held_ops", nd, 3);
        check("held_period_a", t[1] - t[0], 19);
        check("held_period_b", t[2] - t[1], 19);
        repeat (3) @(posedge clk);

        // Reset at cycle 8 of an operation
        #1 start = 1'b1; mode_i = 1'b1; x_i = 16'sd2048; v_i = 16'sd2048;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        rst_n = 1'b1;
        dcnt = n_done;
        repeat (25) @(posedge clk);
        #1 check("abort_no_done", n_done - dcnt, 0);
        do_op(1'b0, 16'sd0, 16'sd1024, lat, bcnt, res);
        check("after_abort_latency", lat, 17);
        check("after_abort_value", res, 1024);

        // TERMS = 1: cos(1.0) collapses to 1.0
        @(posedge clk); #1;
        mode_i = 1'b0; x_i = 16'sd2048; v_i = 16'sd2048; start_t1 = 1'b1;
        @(posedge clk); #1 start_t1 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (done_t1) begin lat = k; break; end
        end
        check("t1_latency", lat, 3);
        check("t1_value", result_t1, 2048);

        // WIDTH = 24, FRAC = 16: cos(0) * 1.0
        @(posedge clk); #1;
        x_w = '0; v_w = 24'sd65536; start_w = 1'b1;
        @(posedge clk); #1 start_w = 1'b0;
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (done_w) begin lat = k; break; end
        end
        check("w24_latency", lat, 17);
        check("w24_value", result_w, 65536);

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
